// File: rtl/snake_segment_writer.sv
// Serialises a packed snake body into one grid write per accepted transfer.
// Optional build macro SNAKE_HEAD_CODE_EN: segment 0 is written with the head code 2'b11.
module snake_segment_writer #(
  parameter int MAX_LEN = 225,
  parameter int COORD_W = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [$clog2(MAX_LEN+1)-1:0]                snake_len,
  input  logic [MAX_LEN*2*COORD_W-1:0]                snake_in,
  input  logic                                        wr_ready,
  output logic                                        wr_en,
  output logic [COORD_W-1:0]                          x_loc,
  output logic [COORD_W-1:0]                          y_loc,
  output logic [1:0]                                  data_out,
  output logic                                        busy,
  output logic                                        done
);

  localparam int SEG_W = 2 * COORD_W;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                      state_r, state_s;
  logic [LEN_W-1:0]            idx_r, idx_s;
  logic [LEN_W-1:0]            len_r, len_s;
  logic [MAX_LEN*SEG_W-1:0]    snap_r;
  logic                        load_s;
  logic [MAX_LEN*SEG_W-1:0]    seg_src_s;
  logic [SEG_W-1:0]            seg_s;

  logic                        wr_en_r, wr_en_s;
  logic [COORD_W-1:0]          x_loc_r, x_loc_s;
  logic [COORD_W-1:0]          y_loc_r, y_loc_s;
  logic [1:0]                  data_out_r, data_out_s;
  logic                        busy_r, busy_s;
  logic                        done_r, done_s;

  // Next-state, index and next-output computation; outputs are registered from these.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    len_s      = len_r;
    load_s     = 1'b0;
    seg_src_s  = snap_r;
    seg_s      = {SEG_W{1'b0}};
    wr_en_s    = 1'b0;
    x_loc_s    = {COORD_W{1'b0}};
    y_loc_s    = {COORD_W{1'b0}};
    data_out_s = 2'b00;
    busy_s     = 1'b0;
    done_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          idx_s   = {LEN_W{1'b0}};
          len_s   = (snake_len > MAX_LEN_C) ? MAX_LEN_C : snake_len;
          if (len_s == {LEN_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          if (idx_r == len_r - 1'b1) begin
            state_s = ST_DONE;
          end else begin
            idx_s = idx_r + 1'b1;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // The first write is presented while the snapshot is still being captured.
    if (load_s) begin
      seg_src_s = snake_in;
    end else begin
      seg_src_s = snap_r;
    end
    seg_s = seg_src_s[idx_s*SEG_W +: SEG_W];

    wr_en_s = (state_s == ST_WRITE);
    busy_s  = (state_s != ST_IDLE);
    done_s  = (state_s == ST_DONE);
    if (wr_en_s) begin
      x_loc_s = seg_s[COORD_W-1:0];
      y_loc_s = seg_s[SEG_W-1:COORD_W];
`ifdef SNAKE_HEAD_CODE_EN
      if (idx_s == {LEN_W{1'b0}}) begin
        data_out_s = 2'b11;
      end else begin
        data_out_s = 2'b10;
      end
`else
      data_out_s = 2'b10;
`endif
    end else begin
      x_loc_s    = {COORD_W{1'b0}};
      y_loc_s    = {COORD_W{1'b0}};
      data_out_s = 2'b00;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {LEN_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      snap_r     <= {(MAX_LEN*SEG_W){1'b0}};
      wr_en_r    <= 1'b0;
      x_loc_r    <= {COORD_W{1'b0}};
      y_loc_r    <= {COORD_W{1'b0}};
      data_out_r <= 2'b00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      len_r      <= len_s;
      if (load_s) begin
        snap_r <= snake_in;
      end else begin
        snap_r <= snap_r;
      end
      wr_en_r    <= wr_en_s;
      x_loc_r    <= x_loc_s;
      y_loc_r    <= y_loc_s;
      data_out_r <= data_out_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign wr_en    = wr_en_r;
  assign x_loc    = x_loc_r;
  assign y_loc    = y_loc_r;
  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_snake_segment_writer.sv
// Randomised bench for snake_segment_writer with a queue-based reference of expected writes.
module tb_snake_segment_writer;

  localparam int MAX_LEN = 225;
  localparam int COORD_W = 4;
  localparam int SEG_W   = 2 * COORD_W;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [LEN_W-1:0]         snake_len;
  logic [MAX_LEN*SEG_W-1:0] snake_in;
  logic                     wr_ready;
  logic                     wr_en;
  logic [COORD_W-1:0]       x_loc;
  logic [COORD_W-1:0]       y_loc;
  logic [1:0]               data_out;
  logic                     busy;
  logic                     done;

  int checks_n = 0;
  int errors_n = 0;

  snake_segment_writer #(.MAX_LEN(MAX_LEN), .COORD_W(COORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .snake_len(snake_len), .snake_in(snake_in),
    .wr_ready(wr_ready), .wr_en(wr_en), .x_loc(x_loc), .y_loc(y_loc),
    .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] cell_code(input int k);
`ifdef SNAKE_HEAD_CODE_EN
    return (k == 0) ? 2'b11 : 2'b10;
`else
    return 2'b10;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_xy"}, {24'd0, y_loc, x_loc}, 32'd0);
    check_val({tag, "_data"}, 32'(data_out), 32'd0);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 three stalls on the first write
  task automatic run_seq(input string tag, input int len_req, input int ready_mode, input bit disturb);
    logic [SEG_W+1:0] exp_q[$];
    logic [SEG_W+1:0] cur;
    logic [SEG_W-1:0] s;
    int eff;
    int cyc;
    int stalls;
    int xfers;
    bit rdy;
    eff = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    for (int i = 0; i < MAX_LEN; i++) begin
      s = SEG_W'($urandom);
      snake_in[i*SEG_W +: SEG_W] = s;
      if (i < eff) exp_q.push_back({cell_code(i), s});
    end
    snake_len = LEN_W'(len_req);
    start = 1'b1;
    wr_ready = 1'b1;
    step();
    start = 1'b0;
    snake_len = LEN_W'($urandom);
    cyc = 1;
    stalls = 0;
    xfers = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      cur = exp_q[0];
      check_val({tag, "_wr_en"}, 32'(wr_en), 32'd1);
      check_val({tag, "_x"}, 32'(x_loc), 32'(cur[COORD_W-1:0]));
      check_val({tag, "_y"}, 32'(y_loc), 32'(cur[SEG_W-1:COORD_W]));
      check_val({tag, "_data"}, 32'(data_out), 32'(cur[SEG_W+1:SEG_W]));
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      check_val({tag, "_done_early"}, 32'(done), 32'd0);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(xfers == 0 && stalls < 3);
        default: rdy = 1'b1;
      endcase
      if (disturb && cyc == 2) begin
        snake_in = ~snake_in;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      wr_ready = rdy;
      step();
      if (rdy) begin
        void'(exp_q.pop_front());
        xfers++;
      end else begin
        stalls++;
      end
      cyc++;
    end
    start = 1'b0;
    check_val({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_done_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_done_wr_en"}, 32'(wr_en), 32'd0);
    wr_ready = 1'($urandom_range(0, 1));
    step();
    check_idle({tag, "_after"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b1;
    snake_len = LEN_W'(3);
    snake_in = '0;
    wr_ready = 1'b1;
    step();
    step();
    check_idle("reset");
    start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("post_reset");
    end

    // Basic sequence with fixed coordinates (5,7), (4,7), (3,7).
    snake_in = '0;
    snake_in[0*SEG_W +: SEG_W] = 8'h75;
    snake_in[1*SEG_W +: SEG_W] = 8'h74;
    snake_in[2*SEG_W +: SEG_W] = 8'h73;
    snake_len = LEN_W'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("basic_w0", {22'd0, data_out, wr_en, busy, y_loc, x_loc}, {22'd0, cell_code(0), 2'b11, 8'h75});
    step();
    check_val("basic_w1", {22'd0, data_out, wr_en, busy, y_loc, x_loc}, {22'd0, 2'b10, 2'b11, 8'h74});
    step();
    check_val("basic_w2", {22'd0, data_out, wr_en, busy, y_loc, x_loc}, {22'd0, 2'b10, 2'b11, 8'h73});
    step();
    check_val("basic_done", {29'd0, done, busy, wr_en}, {29'd0, 3'b110});
    step();
    check_idle("basic_after");

    run_seq("backpressure", 2, 2, 1'b0);
    run_seq("len_zero", 0, 1, 1'b0);
    run_seq("len_over", MAX_LEN + 5, 0, 1'b0);
    run_seq("snapshot", 6, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("ignored_start");
    end

    for (int r = 0; r < 6; r++) begin
      run_seq("random", $urandom_range(1, 12), 1, 1'b0);
    end
    run_seq("random_full", MAX_LEN, 1, 1'b0);

    // Reset after the 4th transfer of a 10-segment sequence.
    for (int i = 0; i < MAX_LEN; i++) snake_in[i*SEG_W +: SEG_W] = SEG_W'($urandom);
    snake_len = LEN_W'(10);
    start = 1'b1;
    wr_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_val("midrst_pre_wr_en", 32'(wr_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("midrst_async");
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("midrst_no_done");
    end
    run_seq("after_midrst", 10, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end

endmodule
